// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU control logic and alu_exec_unit.
// slave = execution unit side, master = requester/consumer side.
interface alu_exec_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;

    modport slave (
        input  in_valid, alu_op, op_a, op_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

    modport master (
        output in_valid, alu_op, op_a, op_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU with valid/ready handshake; sll is iterative unless the
// ALU_FAST_SHIFT_EN macro selects a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_exec_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_illegal;

    logic [DATA_W-1:0] w_alu_res;
    logic              w_illegal;
    logic              w_sll_iter;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_shift_next;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_alu_res = '0;
        w_illegal = 1'b0;
        unique case (bus.alu_op)
            4'b0000, 4'b0010, 4'b0011: w_alu_res = bus.op_a + bus.op_b;
            4'b1000:                   w_alu_res = bus.op_a - bus.op_b;
            4'b0101, 4'b0110:          w_alu_res = bus.op_a & bus.op_b;
            4'b0111:                   w_alu_res = ~(bus.op_a | bus.op_b);
            4'b1011: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            4'b1001, 4'b1010:          w_alu_res = bus.op_a;
`ifdef ALU_FAST_SHIFT_EN
            4'b0100:                   w_alu_res = bus.op_b << bus.shamt;
`else
            // Only reached with shamt == 0; nonzero amounts go through SHIFT.
            4'b0100:                   w_alu_res = bus.op_b;
`endif
            default: begin
                w_alu_res = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign w_sll_iter = 1'b0;
`else
    assign w_sll_iter = (bus.alu_op == 4'b0100) && (bus.shamt != 5'd0);
`endif

    assign w_in_ready   = rst_n && (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_shift_next = r_shreg << 1;

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: r_shreg is pure datapath and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_sll_iter) begin
                            r_shreg     <= bus.op_b;
                            r_cnt       <= bus.shamt;
                            r_state     <= SHIFT;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                        end
                    end else if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == 5'd1) begin
                        r_result    <= w_shift_next;
                        r_zero      <= (w_shift_next == '0);
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_shreg <= w_shift_next;
                        r_cnt   <= r_cnt - 5'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for latency-1 ops, then
// hand sequences for sll timing, backpressure and reset mid-operation.
module tb_alu_exec_unit;
    logic clk;
    logic rst_n;
    int   n_err = 0;
    int   n_chk = 0;

    alu_exec_if #(.DATA_W(32)) bus ();

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        ill;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.shamt    = sh;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen_valid;

        vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b0};
        vecs[1]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{4'b0011, 32'h00000005, 32'h00000007, 5'd0, 32'h0000000C, 1'b0, 1'b0};
        vecs[3]  = '{4'b1000, 32'h00001234, 32'h00001234, 5'd0, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{4'b1000, 32'h00000005, 32'h00000007, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[5]  = '{4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0110, 32'hFFFF0000, 32'h12345678, 5'd0, 32'h12340000, 1'b0, 1'b0};
        vecs[7]  = '{4'b0111, 32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[8]  = '{4'b0111, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{4'b1011, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0};
        vecs[10] = '{4'b1011, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1, 1'b0};
        vecs[11] = '{4'b1011, 32'h80000000, 32'h7FFFFFFF, 5'd0, 32'h00000001, 1'b0, 1'b0};
        vecs[12] = '{4'b1001, 32'hDEADBEEF, 32'h11111111, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[13] = '{4'b1010, 32'h00000000, 32'h22222222, 5'd0, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{4'b0100, 32'h33333333, 32'h0000ABCD, 5'd0, 32'h0000ABCD, 1'b0, 1'b0};
        vecs[15] = '{4'b0001, 32'h00000005, 32'h00000007, 5'd0, 32'h00000000, 1'b1, 1'b1};
        vecs[16] = '{4'b1100, 32'hAAAAAAAA, 32'h55555555, 5'd3, 32'h00000000, 1'b1, 1'b1};
        vecs[17] = '{4'b1101, 32'h00000001, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b1};
        vecs[18] = '{4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1, 1'b1};
        vecs[19] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 5'd7, 32'h00000000, 1'b1, 1'b1};
        vecs[20] = '{4'b0000, 32'h00000010, 32'h00000020, 5'd0, 32'h00000030, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);

        // Reset state
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_in_ready2", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Latency-1 vectors, back-to-back with out_ready high
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            check($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
            tick();
            check($sformatf("v%0d_out_valid", i), bus.out_valid, 1);
            check($sformatf("v%0d_result", i), bus.result, vecs[i].res);
            check($sformatf("v%0d_zero", i), bus.zero, vecs[i].z);
            check($sformatf("v%0d_illegal", i), bus.illegal, vecs[i].ill);
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        tick();
        check("drain_out_valid", bus.out_valid, 0);

        // sll b=3 shamt=4
        drive(1'b1, 4'b0100, 32'h0, 32'h00000003, 5'd4);
        tick();
`ifdef ALU_FAST_SHIFT_EN
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        check("sll_fast_valid", bus.out_valid, 1);
        check("sll_fast_result", bus.result, 32'h00000030);
`else
        // A competing add during SHIFT must be ignored.
        drive(1'b1, 4'b0000, 32'h1, 32'h1, 5'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sll_busy%0d_in_ready", i), bus.in_ready, 0);
            check($sformatf("sll_busy%0d_out_valid", i), bus.out_valid, 0);
            tick();
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        check("sll_iter_valid", bus.out_valid, 1);
        check("sll_iter_result", bus.result, 32'h00000030);
        check("sll_iter_zero", bus.zero, 0);
`endif

        // Backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_valid", i), bus.out_valid, 1);
            check($sformatf("hold%0d_result", i), bus.result, 32'h00000030);
            check($sformatf("hold%0d_zero", i), bus.zero, 0);
            check($sformatf("hold%0d_in_ready", i), bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 4'b0111, 32'h0, 32'h0, 5'd0);
        #1;
        check("b2b_in_ready", bus.in_ready, 1);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_result", bus.result, 32'hFFFFFFFF);
        tick();
        check("b2b_drain", bus.out_valid, 0);

        // Reset with a pending result discards it
        bus.out_ready = 1'b0;
        drive(1'b1, 4'b0011, 32'h4, 32'h5, 5'd0);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        check("pend_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        tick();
        check("pend_rst_valid", bus.out_valid, 0);
        check("pend_rst_result", bus.result, 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Reset during sll shamt=31
        drive(1'b1, 4'b0100, 32'h0, 32'h00000001, 5'd31);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("shift_rst_valid", bus.out_valid, 0);
        check("shift_rst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("shift_rst_idle", bus.in_ready, 1);
        seen_valid = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (bus.out_valid) seen_valid++;
        end
        check("shift_rst_no_output", seen_valid, 0);

        // Unit still works after the aborted shift
        drive(1'b1, 4'b1000, 32'h00000010, 32'h00000001, 5'd0);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        check("post_abort_valid", bus.out_valid, 1);
        check("post_abort_result", bus.result, 32'h0000000F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width (only 32 supported).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port alu_op  input  4  operation code from the ALU control unit.
REQ-007 SHALL have port op_a  input  DATA_W  operand A (rs value, or link address for jal).
REQ-008 SHALL have port op_b  input  DATA_W  operand B (rt value or sign-extended immediate).
REQ-009 SHALL have port shamt  input  5  shift amount for sll.
REQ-010 SHALL have port out_valid  output  1  result registered and pending.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-012 SHALL have port result  output  DATA_W  operation result.
REQ-013 SHALL have port zero  output  1  high when result equals 0.
REQ-014 SHALL have port illegal  output  1  high when the accepted alu_op is unassigned.

Function
REQ-015 Request SHALL be accepted on a rising edge with in_valid && in_ready; alu_op, op_a, op_b, shamt captured at that edge.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), allowing back-to-back acceptance on result drain.
REQ-017 Op mapping SHALL be: 0000/0010/0011 a+b mod 2^32; 1000 a-b mod 2^32; 0101/0110 a&b; 0111 ~(a|b); 1011 signed(a)<signed(b) ? 1 : 0; 1001/1010 a; 0100 b<<shamt.
REQ-018 Codes 0001, 1100-1111 SHALL produce result 0, zero 1, illegal 1; all other codes illegal 0.
REQ-019 zero SHALL be registered together with result and equal (result==0); for 1000 it is the beq taken flag.
REQ-020 FSM states SHALL be IDLE, SHIFT; non-sll ops and sll with shamt==0 stay in IDLE and raise out_valid at the edge after acceptance (latency 1).
REQ-021 sll with shamt>0 SHALL load b into a shift register, load counter with shamt, enter SHIFT, shift left one bit per cycle, decrement counter, and on the edge where counter reaches 0 return to IDLE with out_valid 1 (latency shamt+1, max 32).
REQ-022 While in SHIFT, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-023 out_valid, result, zero, illegal SHALL hold stable while out_valid && !out_ready.
REQ-024 On out_valid && out_ready without a new acceptance, out_valid SHALL clear next edge; with simultaneous acceptance of a latency-1 op, out_valid SHALL stay 1 with the new result.
REQ-025 Overflow SHALL NOT be detected or flagged; add/sub wrap.

Reset
REQ-026 With rst_n low at a rising edge: state IDLE, counter 0, out_valid 0, result 0, zero 0, illegal 0.
REQ-027 Reset asserted mid-SHIFT or with a pending result SHALL discard the operation with no output produced.
REQ-028 in_ready SHALL be 0 during reset cycles and 1 on the first cycle after rst_n rises.

Configuration
REQ-029 Macro ALU_FAST_SHIFT_EN SHALL select shift implementation.
REQ-030 Defined: sll SHALL use a single-cycle barrel shifter, latency 1, SHIFT state never entered.
REQ-031 Undefined: sll SHALL use the iterative behaviour of REQ-021; all other ops identical in both builds.

Verification
REQ-032 Reset then add a=0x7FFFFFFF b=1, out_ready=1 -> next edge out_valid 1, result 0x80000000, zero 0, illegal 0.
REQ-033 beq code 1000 a=b=0x1234 -> result 0, zero 1; slt a=0xFFFFFFFF b=1 -> result 1.
REQ-034 sll b=0x00000003 shamt=4, iterative build -> in_ready 0 for 4 cycles, out_valid on 5th edge, result 0x00000030; fast build -> result on 1st edge.
REQ-035 out_ready held 0 for 3 cycles after result -> result/zero stable, in_ready 0; out_ready 1 with in_valid nor a=b=0 -> next result 0xFFFFFFFF back-to-back.
REQ-036 alu_op 1110 -> result 0, zero 1, illegal 1; rst_n low during sll shamt=31 SHIFT -> out_valid 0, state IDLE after reset.
